// File: rtl/adbg_or1k_pkg.sv
// Shared types and constants for the OR1K debug burst controller.
//   state_e     : burst FSM states
//   CRC_POLY    : reflected CRC-32 polynomial
//   CRC_INIT    : CRC seed loaded on reset and on every command accept
//   crc32_step  : one serial CRC step (one data bit, LSB-first order)
package adbg_or1k_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return {1'b0, crc[31:1]} ^ (fb ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/adbg_crc32.sv
// Running CRC-32 over DW-bit words, parallel equivalent of feeding the word
// LSB first through the serial reflected register. No final inversion.
//   tck_i  : clock
//   rst_i  : synchronous active-high reset, loads CRC_INIT
//   clr_i  : reload CRC_INIT (start of a new burst)
//   en_i   : fold data_i into the CRC this cycle
//   data_i : word to fold in
//   crc_o  : current CRC value
module adbg_crc32
    import adbg_or1k_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          tck_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] data_i,
    output logic [31:0]   crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < int'(DW); i++) begin
            crc_d = crc32_step(crc_d, data_i[i]);
        end
    end

    always_ff @(posedge tck_i) begin
        if (rst_i || clr_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/adbg_or1k_burst_ctrl.sv
// Burst controller in front of the OR1K SPR bus interface (TCK domain).
// Accepts one burst command, issues one single-word strobe per word to the BIU,
// auto-increments the SPR address, streams data over valid/ready ports and keeps
// a running CRC-32 of every word actually transferred.
//   tck_i, rst_i             : clock, synchronous active-high reset
//   cmd_*                    : burst command (valid/ready, we, start addr, word count)
//   abort_i                  : end the burst after the current word
//   wdata_valid_i/wdata_i/wdata_ready_o : write-word stream in
//   rdata_valid_o/rdata_o/rdata_ready_i : read-word stream out
//   biu_*                    : single-word access port to the BIU
//   busy_o, done_o, crc_o    : status, end-of-burst pulse, running CRC
module adbg_or1k_burst_ctrl
    import adbg_or1k_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned CW       = 16,
    parameter int unsigned ADDR_INC = 1
) (
    input  logic          tck_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [CW-1:0] cmd_count_i,
    input  logic          abort_i,
    input  logic          wdata_valid_i,
    input  logic [DW-1:0] wdata_i,
    output logic          wdata_ready_o,
    output logic          rdata_valid_o,
    output logic [DW-1:0] rdata_o,
    input  logic          rdata_ready_i,
    output logic [AW-1:0] biu_addr_o,
    output logic [DW-1:0] biu_data_o,
    output logic          biu_rd_wrn_o,
    output logic          biu_strobe_o,
    input  logic [DW-1:0] biu_data_i,
    input  logic          biu_rdy_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [31:0]   crc_o
);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] count_q;
    logic          we_q;
    logic          abort_q;   // abort seen while an access was in flight
    logic          cmd_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          rd_wrn_q;
    logic [DW-1:0] biu_data_q;
    logic [DW-1:0] rdata_q;
    logic          rdata_valid_q;

    logic          cmd_fire;
    logic          issue_go;
    logic          last_word;
    logic          crc_en;
    logic [DW-1:0] crc_data;
    logic [AW-1:0] addr_next;

    assign cmd_fire  = cmd_valid_i && cmd_ready_q;
    assign last_word = (count_q == CW'(1));
    assign addr_next = addr_q + AW'(ADDR_INC);

    // Strobe is combinational so it lands in the same cycle the BIU reports
    // ready; the FSM leaves ISSUE on that edge, so it can never last two cycles.
    assign issue_go = (state_q == ISSUE) && !abort_i && biu_rdy_i && (!we_q || wdata_valid_i);

    // A write word counts once the BIU finishes it; a read word once the
    // consumer takes it. Dropped read words never reach the CRC.
    assign crc_en   = ((state_q == WAIT) && we_q && biu_rdy_i) ||
                      ((state_q == DRAIN) && rdata_ready_i);
    assign crc_data = we_q ? biu_data_q : rdata_q;

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            we_q          <= 1'b0;
            abort_q       <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_wrn_q      <= 1'b0;
            biu_data_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        addr_q  <= cmd_addr_i;
                        count_q <= cmd_count_i;
                        we_q    <= cmd_we_i;
                        abort_q <= 1'b0;
                        if (cmd_count_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            rd_wrn_q    <= ~cmd_we_i;
                        end
                    end
                end
                ISSUE: begin
                    if (abort_i) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (issue_go) begin
                        state_q <= WAIT;
                        if (we_q) begin
                            biu_data_q <= wdata_i;
                        end
                    end
                end
                WAIT: begin
                    if (biu_rdy_i) begin
                        if (!we_q && !(abort_q || abort_i)) begin
                            rdata_q       <= biu_data_i;
                            rdata_valid_q <= 1'b1;
                            state_q       <= DRAIN;
                        end else begin
                            if (we_q) begin
                                addr_q  <= addr_next;
                                count_q <= count_q - CW'(1);
                            end
                            if (!we_q || last_word || abort_q || abort_i) begin
                                state_q     <= IDLE;
                                cmd_ready_q <= 1'b1;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                abort_q     <= 1'b0;
                            end else begin
                                state_q <= ISSUE;
                            end
                        end
                    end else if (abort_i) begin
                        abort_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    // A completed handshake beats a same-cycle abort.
                    if (rdata_ready_i) begin
                        rdata_valid_q <= 1'b0;
                        addr_q        <= addr_next;
                        count_q       <= count_q - CW'(1);
                        if (last_word || abort_i) begin
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end else if (abort_i) begin
                        rdata_valid_q <= 1'b0;
                        state_q       <= IDLE;
                        cmd_ready_q   <= 1'b1;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    adbg_crc32 #(
        .DW(DW)
    ) u_crc (
        .tck_i (tck_i),
        .rst_i (rst_i),
        .clr_i (cmd_fire),
        .en_i  (crc_en),
        .data_i(crc_data),
        .crc_o (crc_o)
    );

    assign cmd_ready_o   = cmd_ready_q;
    assign wdata_ready_o = issue_go && we_q;
    assign rdata_valid_o = rdata_valid_q;
    assign rdata_o       = rdata_q;
    assign biu_addr_o    = addr_q;
    assign biu_data_o    = biu_data_q;
    assign biu_rd_wrn_o  = rd_wrn_q;
    assign biu_strobe_o  = issue_go;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_adbg_or1k_burst_ctrl.sv
module tb_adbg_or1k_burst_ctrl;

    logic        tck = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [15:0] cmd_count_i;
    logic        abort_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [31:0] wdata_i;
    logic        rdata_valid_o, rdata_ready_i;
    logic [31:0] rdata_o;
    logic [31:0] biu_addr_o, biu_data_o, biu_data_i;
    logic        biu_rd_wrn_o, biu_strobe_o, biu_rdy_i;
    logic        busy_o, done_o;
    logic [31:0] crc_o;

    always #5 tck = ~tck;

    adbg_or1k_burst_ctrl dut (
        .tck_i        (tck),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_count_i  (cmd_count_i),
        .abort_i      (abort_i),
        .wdata_valid_i(wdata_valid_i),
        .wdata_i      (wdata_i),
        .wdata_ready_o(wdata_ready_o),
        .rdata_valid_o(rdata_valid_o),
        .rdata_o      (rdata_o),
        .rdata_ready_i(rdata_ready_i),
        .biu_addr_o   (biu_addr_o),
        .biu_data_o   (biu_data_o),
        .biu_rd_wrn_o (biu_rd_wrn_o),
        .biu_strobe_o (biu_strobe_o),
        .biu_data_i   (biu_data_i),
        .biu_rdy_i    (biu_rdy_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .crc_o        (crc_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- BIU model: rdy drops after a strobe for rtt cycles ----------------
    logic [31:0] rd_words[64];
    int          rd_idx = 0;
    int          rtt    = 3;
    int          bcnt   = 0;

    always @(posedge tck) begin
        if (rst_i) begin
            biu_rdy_i <= 1'b1;
            bcnt      <= 0;
        end else if (biu_strobe_o) begin
            biu_rdy_i <= 1'b0;
            bcnt      <= rtt;
            if (biu_rd_wrn_o) begin
                biu_data_i <= rd_words[rd_idx % 64];
                rd_idx     <= rd_idx + 1;
            end
        end else if (!biu_rdy_i) begin
            if (bcnt <= 1) biu_rdy_i <= 1'b1;
            else           bcnt      <= bcnt - 1;
        end
    end

    // ---------------- Monitor (mid-cycle sampling) ----------------
    logic [31:0] s_addr[$];
    logic        s_rw[$];
    logic [31:0] w_seen[$];
    logic [31:0] r_seen[$];
    int          done_cnt = 0;
    int          viol     = 0;
    logic        p_strobe = 1'b0, p_rw = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_busy = 1'b0;
    logic        p_rwl    = 1'b0;
    logic [31:0] p_rdata  = '0;

    always @(negedge tck) begin
        if (!rst_i) begin
            if (biu_strobe_o) begin
                s_addr.push_back(biu_addr_o);
                s_rw.push_back(biu_rd_wrn_o);
                if (!biu_rdy_i || p_strobe) viol <= viol + 1;
            end
            if (p_strobe && !p_rw) w_seen.push_back(biu_data_o);
            if (rdata_valid_o && rdata_ready_i) r_seen.push_back(rdata_o);
            if (p_valid && !p_ready && rdata_valid_o && (rdata_o !== p_rdata)) viol <= viol + 1;
            if (busy_o && p_busy && (biu_rd_wrn_o !== p_rwl)) viol <= viol + 1;
            if (done_o) done_cnt <= done_cnt + 1;
        end
        p_strobe <= biu_strobe_o && !rst_i;
        p_rw     <= biu_rd_wrn_o;
        p_rwl    <= biu_rd_wrn_o;
        p_valid  <= rdata_valid_o;
        p_ready  <= rdata_ready_i;
        p_rdata  <= rdata_o;
        p_busy   <= busy_o && !rst_i;
    end

    // ---------------- Reference model ----------------
    logic [31:0] crc_tab[256];
    logic [31:0] ew[$];   // words of the current burst, in transfer order

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = c[7:0] ^ 8'(ew[i] >> (8 * k));
                c = crc_tab[b] ^ (c >> 8);
            end
        end
        return c;
    endfunction

    int b_s, b_w, b_r, b_done, b_viol;

    task automatic mark();
        b_s    = s_addr.size();
        b_w    = w_seen.size();
        b_r    = r_seen.size();
        b_done = done_cnt;
        b_viol = viol;
    endtask

    task automatic load_words(input int n, input bit is_read);
        ew.delete();
        for (int i = 0; i < n; i++) begin
            ew.push_back($urandom);
            if (is_read) rd_words[(rd_idx + i) % 64] = ew[i];
        end
    endtask

    task automatic send_cmd(input bit we, input logic [31:0] addr, input int cnt);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_count_i = 16'(cnt);
        @(posedge tck); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_burst(input bit we, input int stall);
        int n;
        int widx;
        int rv;
        bit got;
        n = 0; widx = 0; rv = 0; got = 1'b0;
        while (!got && n < 400) begin
            wdata_valid_i = we && (widx < ew.size()) && ($urandom_range(0, 3) != 0);
            wdata_i       = (widx < ew.size()) ? ew[widx] : $urandom;
            rdata_ready_i = (rv >= stall);
            @(negedge tck);
            if (wdata_valid_i && wdata_ready_o) widx++;
            if (rdata_valid_o) rv = rdata_ready_i ? 0 : rv + 1;
            if (done_o) got = 1'b1;
            @(posedge tck); #1;
            n++;
        end
        wdata_valid_i = 1'b0;
        rdata_ready_i = 1'b0;
        chk("done_seen", got, 1'b1);
    endtask

    task automatic check_burst(input bit we, input logic [31:0] addr, input int n_strb,
                               input int n_data);
        repeat (3) begin @(posedge tck); #1; end
        chk("strobe_count", s_addr.size() - b_s, n_strb);
        for (int i = 0; i < n_strb; i++) begin
            if (b_s + i < s_addr.size()) begin
                chk("strobe_addr", s_addr[b_s + i], 32'(addr + 32'(i)));
                chk("strobe_rd_wrn", s_rw[b_s + i], 1'(!we));
            end
        end
        if (we) begin
            chk("wr_word_count", w_seen.size() - b_w, n_data);
            for (int i = 0; i < n_data; i++)
                if (b_w + i < w_seen.size()) chk("wr_word", w_seen[b_w + i], ew[i]);
        end else begin
            chk("rd_word_count", r_seen.size() - b_r, n_data);
            for (int i = 0; i < n_data; i++)
                if (b_r + i < r_seen.size()) chk("rd_word", r_seen[b_r + i], ew[i]);
        end
        chk("crc", crc_o, ref_crc(n_data));
        chk("done_once", done_cnt - b_done, 1);
        chk("protocol", viol, b_viol);
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_cmd_ready", cmd_ready_o, 1'b1);
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] a;
        bit          we;
        int          cnt, n;

        for (int b = 0; b < 256; b++) begin
            c = 32'(b);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[b] = c;
        end

        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_count_i = '0;
        abort_i = 1'b0; wdata_valid_i = 1'b0; wdata_i = '0; rdata_ready_i = 1'b0;
        repeat (3) @(posedge tck);
        #1;
        chk("rst_cmd_ready", cmd_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_strobe", biu_strobe_o, 1'b0);
        chk("rst_rvalid", rdata_valid_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_wready", wdata_ready_o, 1'b0);
        chk("rst_addr", biu_addr_o, 32'h0);
        chk("rst_bdata", biu_data_o, 32'h0);
        chk("rst_rd_wrn", biu_rd_wrn_o, 1'b0);
        chk("rst_crc", crc_o, 32'hFFFFFFFF);
        rst_i = 1'b0;
        @(posedge tck); #1;

        // Write burst, 4-cycle BIU round trip
        rtt = 3;
        load_words(3, 1'b0);
        mark();
        send_cmd(1'b1, 32'h0000_2000, 3);
        chk("accept_busy", busy_o, 1'b1);
        chk("accept_cmd_ready", cmd_ready_o, 1'b0);
        run_burst(1'b1, 0);
        check_burst(1'b1, 32'h0000_2000, 3, 3);

        // Read burst with consumer stalled 5 cycles per word
        rtt = 2;
        ew.delete();
        ew.push_back(32'hDEADBEEF);
        ew.push_back(32'h12345678);
        rd_words[rd_idx % 64]       = ew[0];
        rd_words[(rd_idx + 1) % 64] = ew[1];
        mark();
        send_cmd(1'b0, 32'h0000_0010, 2);
        run_burst(1'b0, 5);
        check_burst(1'b0, 32'h0000_0010, 2, 2);

        // Zero-length command
        mark();
        send_cmd(1'b1, $urandom, 0);
        chk("cnt0_done", done_o, 1'b1);
        chk("cnt0_crc", crc_o, 32'hFFFFFFFF);
        chk("cnt0_busy", busy_o, 1'b0);
        @(posedge tck); #1;
        chk("cnt0_done_pulse", done_o, 1'b0);
        chk("cnt0_no_strobe", s_addr.size() - b_s, 0);
        chk("cnt0_done_once", done_cnt - b_done, 1);

        // Address wrap
        rtt = 1;
        load_words(2, 1'b0);
        mark();
        send_cmd(1'b1, 32'hFFFF_FFFF, 2);
        run_burst(1'b1, 0);
        check_burst(1'b1, 32'hFFFF_FFFF, 2, 2);

        // Abort during WAIT of word 2 of a 4-word read
        rtt = 3;
        load_words(4, 1'b1);
        a = $urandom;
        mark();
        send_cmd(1'b0, a, 4);
        rdata_ready_i = 1'b1;
        n = 0;
        while ((s_addr.size() - b_s) < 2 && n < 200) begin
            @(posedge tck); #1;
            n++;
        end
        chk("abort_reach_word2", s_addr.size() - b_s, 2);
        abort_i = 1'b1;
        @(posedge tck); #1;
        abort_i = 1'b0;
        n = 0;
        while (!busy_o == 1'b0 && n < 200) begin
            @(posedge tck); #1;
            n++;
        end
        rdata_ready_i = 1'b0;
        check_burst(1'b0, a, 2, 1);

        // Reset while a write is in WAIT
        rtt = 3;
        load_words(3, 1'b0);
        mark();
        send_cmd(1'b1, $urandom, 3);
        wdata_valid_i = 1'b1;
        wdata_i       = ew[0];
        n = 0;
        while ((s_addr.size() - b_s) < 1 && n < 200) begin
            @(posedge tck); #1;
            n++;
        end
        wdata_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge tck); #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready_o, 1'b1);
        chk("mid_rst_strobe", biu_strobe_o, 1'b0);
        chk("mid_rst_done", done_o, 1'b0);
        rst_i = 1'b0;
        repeat (3) begin @(posedge tck); #1; end
        chk("mid_rst_no_done", done_cnt - b_done, 0);
        chk("mid_rst_crc", crc_o, 32'hFFFFFFFF);

        // Burst after reset
        rtt = 2;
        load_words(3, 1'b1);
        a = $urandom;
        mark();
        send_cmd(1'b0, a, 3);
        run_burst(1'b0, 1);
        check_burst(1'b0, a, 3, 3);

        // Randomized bursts
        for (int t = 0; t < 4; t++) begin
            we  = 1'($urandom_range(0, 1));
            a   = $urandom;
            cnt = $urandom_range(1, 4);
            rtt = $urandom_range(1, 4);
            load_words(cnt, !we);
            mark();
            send_cmd(we, a, cnt);
            run_burst(we, $urandom_range(0, 2));
            check_burst(we, a, cnt, cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
